// File: rtl/ram_dp_pipe.sv
// ============================================================================
// Module   : ram_dp_pipe
// Brief    : True dual-port byte-enable RAM with a read pipeline of
//            configurable length and a one-cycle read-valid per port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_dp_pipe #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter     INIT_FILE    = "none"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  output logic                    a_rvalid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   b_rdata
);

  localparam int C_NB    = DATA_WIDTH / 8;
  localparam int C_DEPTH = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("ram_dp_pipe: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("ram_dp_pipe: READ_LATENCY must be in 1..8");
  end

  logic [DATA_WIDTH-1:0] mem_q [C_DEPTH];

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [C_NB-1:0]       be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < C_NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  logic                  w_a_wr;
  logic                  w_b_wr;
  logic [1:0]            w_rd;
  logic [DATA_WIDTH-1:0] w_samp [2];
  logic [1:0]            w_rvalid;
  logic [DATA_WIDTH-1:0] w_rdata [2];

  assign w_a_wr = rst_n & a_req & a_we;
  assign w_b_wr = rst_n & b_req & b_we;
  assign w_rd   = {b_req & ~b_we, a_req & ~a_we};

  // New-data mode folds the opposite port's same-cycle write into the sample.
  always_comb begin
    w_samp[0] = mem_q[a_addr];
    w_samp[1] = mem_q[b_addr];
    if (RDW_MODE != 0 && w_b_wr && (b_addr == a_addr))
      w_samp[0] = merge_bytes(mem_q[a_addr], b_wdata, b_be);
    if (RDW_MODE != 0 && w_a_wr && (a_addr == b_addr))
      w_samp[1] = merge_bytes(mem_q[b_addr], a_wdata, a_be);
  end

  // Port A's byte writes come last so they win on overlapping enables.
  always_ff @(posedge clk) begin
    for (int i = 0; i < C_NB; i++) begin
      if (w_b_wr && b_be[i]) mem_q[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
      if (w_a_wr && a_be[i]) mem_q[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    // Stages only load on a valid beat, so the last stage holds the most recent read.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= w_rd[p];
        if (w_rd[p]) dat_q[0] <= w_samp[p];
        for (int i = 1; i < READ_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign w_rvalid[p] = vld_q[READ_LATENCY-1];
    assign w_rdata[p]  = dat_q[READ_LATENCY-1];
  end

  assign a_rvalid = w_rvalid[0];
  assign a_rdata  = w_rdata[0];
  assign b_rvalid = w_rvalid[1];
  assign b_rdata  = w_rdata[1];

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_pipe.sv
// ============================================================================
// Module   : tb_ram_dp_pipe
// Brief    : Self-checking bench for ram_dp_pipe against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_dp_pipe;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int NB  = DW / 8;
  localparam int LAT = 3;
  localparam int RDW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [NB-1:0] a_be, b_be;
  logic          a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;

  always #5 clk = ~clk;

  ram_dp_pipe #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(LAT),
    .RDW_MODE    (RDW),
    .INIT_FILE   ("none")
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_be    (a_be),
    .a_rvalid(a_rvalid),
    .a_rdata (a_rdata),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_be    (b_be),
    .b_rvalid(b_rvalid),
    .b_rdata (b_rdata)
  );

  // Reference model: a word array plus a queue of (due cycle, data) per port.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           qa[$];
  rd_t           qb[$];
  logic [DW-1:0] mdl_mem [1 << AW];
  logic          exp_av = 1'b0, exp_bv = 1'b0;
  logic [DW-1:0] exp_ad = '0, exp_bd = '0;
  int            cyc = 0;
  bit            started = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // Applies the inputs that the coming rising edge will sample.
  task automatic model_step();
    logic [DW-1:0] w;
    cyc++;
    exp_av = 1'b0;
    exp_bv = 1'b0;
    if (rst_n !== 1'b1) begin
      qa.delete();
      qb.delete();
      exp_ad  = '0;
      exp_bd  = '0;
      started = 1'b1;
    end else begin
      if (a_req && !a_we) begin
        w = mdl_mem[a_addr];
        if (RDW != 0 && b_req && b_we && b_addr == a_addr) w = merge(w, b_wdata, b_be);
        qa.push_back('{due: cyc + LAT - 1, data: w});
      end
      if (b_req && !b_we) begin
        w = mdl_mem[b_addr];
        if (RDW != 0 && a_req && a_we && a_addr == b_addr) w = merge(w, a_wdata, a_be);
        qb.push_back('{due: cyc + LAT - 1, data: w});
      end
      if (b_req && b_we) mdl_mem[b_addr] = merge(mdl_mem[b_addr], b_wdata, b_be);
      if (a_req && a_we) mdl_mem[a_addr] = merge(mdl_mem[a_addr], a_wdata, a_be);
      if (qa.size() > 0 && qa[0].due == cyc) begin
        exp_av = 1'b1;
        exp_ad = qa[0].data;
        void'(qa.pop_front());
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        exp_bv = 1'b1;
        exp_bd = qb[0].data;
        void'(qb.pop_front());
      end
    end
  endtask

  // Falling edge: outputs reflect the last rising edge, inputs are set for the next one.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk1("a_rvalid", a_rvalid, exp_av);
        chk1("b_rvalid", b_rvalid, exp_bv);
        chk("a_rdata", a_rdata, exp_ad);
        chk("b_rdata", b_rdata, exp_bd);
      end
      model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
  endtask

  task automatic wr_a(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [NB-1:0] be);
    a_req = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = d; a_be = be;
  endtask

  task automatic wr_b(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [NB-1:0] be);
    b_req = 1'b1; b_we = 1'b1; b_addr = ad; b_wdata = d; b_be = be;
  endtask

  task automatic rd_a(input logic [AW-1:0] ad);
    a_req = 1'b1; a_we = 1'b0; a_addr = ad;
  endtask

  task automatic rd_b(input logic [AW-1:0] ad);
    b_req = 1'b1; b_we = 1'b0; b_addr = ad;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 127));
    return AW'($urandom_range(0, 3));
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) step();
    chk1("reset_a_rvalid", a_rvalid, 1'b0);
    chk("reset_b_rdata", b_rdata, 32'h0);
    rst_n = 1'b1;

    // Give every address the random phase touches a defined value.
    for (int i = 0; i < 64; i++) begin
      idle();
      wr_a(AW'(i), $urandom, 4'hF);
      wr_b(AW'(i + 64), $urandom, 4'hF);
      step();
    end

    // Write then read on the other port; rvalid after edge k+LAT-1.
    idle(); wr_a(10'h010, 32'hDEADBEEF, 4'hF); step();
    idle(); rd_b(10'h010); step();
    idle(); step();
    chk1("t1_not_yet", b_rvalid, 1'b0);
    step();
    chk1("t1_rvalid", b_rvalid, 1'b1);
    chk("t1_rdata", b_rdata, 32'hDEADBEEF);
    step();
    chk1("t1_pulse", b_rvalid, 1'b0);
    chk("t1_hold", b_rdata, 32'hDEADBEEF);

    // Partial byte-enable write.
    idle(); wr_a(10'h020, 32'h11223344, 4'hF); step();
    idle(); wr_a(10'h020, 32'hAABBCCDD, 4'b0101); step();
    idle(); rd_a(10'h020); step();
    idle(); step(); step();
    chk1("t2_rvalid", a_rvalid, 1'b1);
    chk("t2_rdata", a_rdata, 32'h11BB33DD);

    // Dual write to one address, A wins overlap.
    idle(); wr_a(10'h030, 32'h0, 4'hF); step();
    idle(); wr_a(10'h030, 32'hFFFFFFFF, 4'b0011); wr_b(10'h030, 32'h0, 4'b0110); step();
    idle(); rd_b(10'h030); step();
    idle(); step(); step();
    chk("t3_rdata", b_rdata, 32'h0000FFFF);

    // Read-during-write collision, then read the cycle after a write.
    idle(); wr_a(10'h040, 32'h1, 4'hF); step();
    idle(); wr_a(10'h040, 32'h2, 4'hF); rd_b(10'h040); step();
    idle(); step(); step();
    chk("t4_rdw", b_rdata, (RDW != 0) ? 32'h2 : 32'h1);
    idle(); wr_a(10'h040, 32'h3, 4'hF); step();
    idle(); rd_b(10'h040); step();
    idle(); step(); step();
    chk("t4_raw", b_rdata, 32'h3);

    // Back-to-back reads stream with no gaps.
    for (int i = 0; i < 8; i++) begin
      idle(); wr_b(AW'(i), 32'hC0DE0000 + 32'(i), 4'hF); step();
    end
    for (int j = 0; j < 10; j++) begin
      idle();
      if (j < 8) rd_b(AW'(j));
      step();
      if (j >= 2) begin
        chk1("t5_rvalid", b_rvalid, 1'b1);
        chk("t5_rdata", b_rdata, 32'hC0DE0000 + 32'(j - 2));
      end
    end
    idle(); step();
    chk1("t5_end", b_rvalid, 1'b0);

    // Reset flushes in-flight reads and blocks writes; memory survives.
    idle(); rd_a(10'h010); rd_b(10'h020); step();
    idle(); rd_b(10'h030); step();
    idle(); rst_n = 1'b0; wr_a(10'h010, 32'h0, 4'hF); step();
    chk1("t6_a_rvalid", a_rvalid, 1'b0);
    chk1("t6_b_rvalid", b_rvalid, 1'b0);
    chk("t6_a_rdata", a_rdata, 32'h0);
    chk("t6_b_rdata", b_rdata, 32'h0);
    rst_n = 1'b1; idle(); step();
    chk1("t6_flush_a", a_rvalid, 1'b0);
    step();
    chk1("t6_flush_b", b_rvalid, 1'b0);
    idle(); rd_a(10'h010); step();
    idle(); step(); step();
    chk("t6_preserved", a_rdata, 32'hDEADBEEF);

    // Randomised traffic with frequent address collisions and rare resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      a_req   = 1'($urandom_range(0, 1));
      a_we    = 1'($urandom_range(0, 1));
      a_addr  = rand_addr();
      a_wdata = $urandom;
      a_be    = NB'($urandom);
      b_req   = 1'($urandom_range(0, 1));
      b_we    = 1'($urandom_range(0, 1));
      b_addr  = rand_addr();
      b_wdata = $urandom;
      b_be    = NB'($urandom);
      step();
    end

    idle();
    rst_n = 1'b1;
    repeat (6) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
